alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
Instruction fetch/decode/writeback controller that drives the 32-bit ALU's control inputs and consumes its results (C, F3, addrch, naddr). It owns the program counter, a 16x32 register file and flags F1/F2. It sits between instruction memory and the ALU and issues one instruction per multi-cycle pass.

Parameters:
ADDR_W, 16, instruction memory address width (PC width)
RESET_PC, 0, PC value loaded on reset
HALT_OP, 127, opcode that stops sequencing

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
imem_req  out  1  fetch request, held until imem_valid
imem_addr  out  ADDR_W  fetch address (= PC)
imem_valid  in  1  fetch data valid strobe
imem_data  in  32  instruction word
alu_instr  out  7  ALU opcode
alu_a  out  32  regfile[rs1]
alu_b  out  32  regfile[rs2]
alu_reg8  out  32  regfile[8], always live
alu_value  out  16  immediate
alu_highlow  out  1  load half select
alu_f1  out  1  flag F1
alu_f2  out  1  flag F2
alu_en  out  1  drives the ALU clock/enable input; high only in EXEC
alu_c  in  32  ALU result
alu_f3  in  1  ALU compare flag
alu_addrch  in  1  ALU branch-taken
alu_naddr  in  32  ALU branch target
pc  out  ADDR_W  current PC
halted  out  1  high in HALT state

Behaviour:
- Instruction format: op[31:25], rd[24:21], rs1[20:17], highlow[16], imm[15:0]; rs2 = imm[3:0].
- States: FETCH -> DECODE -> EXEC -> WB -> FETCH; HALT absorbing.
- FETCH: imem_req=1, imem_addr=pc; on imem_valid latch imem_data into IR, go DECODE. Zero-wait valid gives 1 FETCH cycle.
- DECODE: register alu_instr, alu_a, alu_b, alu_value, alu_highlow from IR and regfile. If op==HALT_OP go HALT, else EXEC.
- EXEC: alu_en=1 for exactly one cycle; alu_c, alu_f3, alu_addrch and alu_naddr are sampled at the end of this cycle.
- WB:
  - op 0-7: regfile[rd] <= sampled C.
  - op 8-13: F1 <= sampled F3; F2 <= old F1.
  - op 14-15: if addrch, pc <= naddr[ADDR_W-1:0], else pc+1.
  - Every other op: pc <= pc+1, wrapping modulo 2^ADDR_W.
  - Op 16-126 are NOPs: no register or flag write.
- Minimum latency is 4 cycles per instruction.
- Regfile: 16x32. All 16 registers are writable. A write to r8 is visible on alu_reg8 the cycle after WB.
- alu_en, imem_req and halted are 0 outside their states.
- imem_valid outside FETCH is ignored.
- Reset (any state, including mid-fetch): state=FETCH, pc=RESET_PC, IR=0, F1=F2=0, regfile all 0, alu_instr=0, alu_a=alu_b=0, alu_value=0, alu_highlow=0, alu_en=0, imem_req=0 in the reset cycle. Fetch begins the cycle after reset deasserts.
- HALT: halted=1 and pc frozen; only reset exits.

Optional Feature:
ALU_SEQ_RETIRE_CNT_EN: adds output retired[31:0], reset to 0 and incremented in each WB cycle, wrapping at 2^32 (HALT does not count). Without the macro the port and counter do not exist.

Decomposition:
- Package alu_seq_pkg:
  - state enum {FETCH, DECODE, EXEC, WB, HALT}
  - opcode constants: OP_ADD=0, OP_SUB=1, OP_SHL=2, OP_SHR=3, OP_MOV=4, OP_LDL=5, OP_LDH=6, OP_MOV7=7, OP_EQ=8, OP_LT=9, OP_GT=10, OP_NF=11, OP_AND=12, OP_NF13=13, OP_JMP=14, OP_BR=15
  - instruction field bit positions
- One sub-module, alu_seq_regfile: 16x32, one write port, two read ports plus a dedicated r8 tap.

Test Plan:
- Reset mid-FETCH with imem_req=1 -> next cycle imem_req=0, pc=0. The first fetch after deassert uses imem_addr=0.
- Register write: preload r1=5, r2=7 via OP_LDL, then ADD rd=3, rs1=1, rs2=2 -> r3=12; alu_en high exactly 1 cycle.
- imem_valid delayed 3 cycles -> imem_req held and state stays FETCH; IR latched on the valid cycle only.
- OP_EQ with r1=r2=9 and alu_f3=1 -> F1=1, F2=previous F1 (0).
- OP_BR with alu_addrch=1, naddr=0x20 -> next imem_addr=0x20. With addrch=0 -> pc+1. pc=0xFFFF non-branch -> wraps to 0.
- HALT_OP fetched -> halted=1, no further imem_req. Reset -> halted=0, pc=0. With ALU_SEQ_RETIRE_CNT_EN, retired=3 after 3 completed instructions.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types, opcodes and instruction field positions for alu_sequencer.
package alu_seq_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_REGS = 16;
    localparam int unsigned REG_AW   = 4;
    localparam int unsigned OP_W     = 7;

    // Instruction word layout
    localparam int unsigned OP_MSB  = 31;
    localparam int unsigned OP_LSB  = 25;
    localparam int unsigned RD_MSB  = 24;
    localparam int unsigned RD_LSB  = 21;
    localparam int unsigned RS1_MSB = 20;
    localparam int unsigned RS1_LSB = 17;
    localparam int unsigned HL_BIT  = 16;
    localparam int unsigned IMM_MSB = 15;
    localparam int unsigned IMM_LSB = 0;
    localparam int unsigned RS2_MSB = 3;
    localparam int unsigned RS2_LSB = 0;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, WB, HALT} state_e;

    localparam logic [OP_W-1:0] OP_ADD  = 7'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 7'd1;
    localparam logic [OP_W-1:0] OP_SHL  = 7'd2;
    localparam logic [OP_W-1:0] OP_SHR  = 7'd3;
    localparam logic [OP_W-1:0] OP_MOV  = 7'd4;
    localparam logic [OP_W-1:0] OP_LDL  = 7'd5;
    localparam logic [OP_W-1:0] OP_LDH  = 7'd6;
    localparam logic [OP_W-1:0] OP_MOV7 = 7'd7;
    localparam logic [OP_W-1:0] OP_EQ   = 7'd8;
    localparam logic [OP_W-1:0] OP_LT   = 7'd9;
    localparam logic [OP_W-1:0] OP_GT   = 7'd10;
    localparam logic [OP_W-1:0] OP_NF   = 7'd11;
    localparam logic [OP_W-1:0] OP_AND  = 7'd12;
    localparam logic [OP_W-1:0] OP_NF13 = 7'd13;
    localparam logic [OP_W-1:0] OP_JMP  = 7'd14;
    localparam logic [OP_W-1:0] OP_BR   = 7'd15;

    // Ops whose result lands in regfile[rd]
    function automatic logic op_writes_reg(input logic [OP_W-1:0] op);
        return op <= OP_MOV7;
    endfunction

    // Compare ops shift the flag pair
    function automatic logic op_writes_flags(input logic [OP_W-1:0] op);
        return (op >= OP_EQ) && (op <= OP_NF13);
    endfunction

    // Ops that may redirect the PC
    function automatic logic op_is_branch(input logic [OP_W-1:0] op);
        return (op == OP_JMP) || (op == OP_BR);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: instruction-memory fetch handshake plus the ALU control/result bundle.
interface alu_seq_if #(parameter int unsigned ADDR_W = 16);
    import alu_seq_pkg::*;

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_valid;
    logic [DATA_W-1:0] imem_data;

    logic [OP_W-1:0]   alu_instr;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_reg8;
    logic [15:0]       alu_value;
    logic              alu_highlow;
    logic              alu_f1;
    logic              alu_f2;
    logic              alu_en;
    logic [DATA_W-1:0] alu_c;
    logic              alu_f3;
    logic              alu_addrch;
    logic [DATA_W-1:0] alu_naddr;

    modport master (
        output imem_req, imem_addr, alu_instr, alu_a, alu_b, alu_reg8, alu_value,
               alu_highlow, alu_f1, alu_f2, alu_en,
        input  imem_valid, imem_data, alu_c, alu_f3, alu_addrch, alu_naddr
    );

    modport slave (
        input  imem_req, imem_addr, alu_instr, alu_a, alu_b, alu_reg8, alu_value,
               alu_highlow, alu_f1, alu_f2, alu_en,
        output imem_valid, imem_data, alu_c, alu_f3, alu_addrch, alu_naddr
    );

endinterface

// File: rtl/alu_seq_regfile.sv
// alu_seq_regfile: 16x32 register file, one write port, two async read ports, r8 tap.
module alu_seq_regfile
    import alu_seq_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [REG_AW-1:0] raddr_a_i,
    input  logic [REG_AW-1:0] raddr_b_i,
    output logic [DATA_W-1:0] rdata_a_o,
    output logic [DATA_W-1:0] rdata_b_o,
    output logic [DATA_W-1:0] r8_o
);

    logic [NUM_REGS-1:0][DATA_W-1:0] rf_q;

    // Storage: cleared on reset, single write per cycle
    always_ff @(posedge clock) begin
        if (reset)     rf_q <= '0;
        else if (we_i) rf_q[waddr_i] <= wdata_i;
    end

    assign rdata_a_o = rf_q[raddr_a_i];
    assign rdata_b_o = rf_q[raddr_b_i];
    assign r8_o      = rf_q[8];

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: fetch/decode/exec/writeback controller around an external 32-bit ALU.
// Optional retire counter output enabled by defining ALU_SEQ_RETIRE_CNT_EN.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [OP_W-1:0]   HALT_OP  = 7'd127
) (
    input  logic              clock,
    input  logic              reset,
    alu_seq_if.master         bus,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
`ifdef ALU_SEQ_RETIRE_CNT_EN
    ,
    output logic [31:0]       retired
`endif
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              f1_q, f1_d, f2_q, f2_d;
    logic [OP_W-1:0]   instr_q, instr_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [15:0]       value_q, value_d;
    logic              hl_q, hl_d;
    logic [DATA_W-1:0] c_q, c_d;
    logic              f3_q, f3_d, ac_q, ac_d;
    logic [ADDR_W-1:0] naddr_q, naddr_d;
    logic              rf_we;
    logic [DATA_W-1:0] rd_a, rd_b, r8;
    logic [OP_W-1:0]   ir_op;
    logic              unused_naddr_hi;

    assign ir_op           = ir_q[OP_MSB:OP_LSB];
    assign unused_naddr_hi = ^bus.alu_naddr[DATA_W-1:ADDR_W];

    alu_seq_regfile u_rf (
        .clock     (clock),
        .reset     (reset),
        .we_i      (rf_we),
        .waddr_i   (ir_q[RD_MSB:RD_LSB]),
        .wdata_i   (c_q),
        .raddr_a_i (ir_q[RS1_MSB:RS1_LSB]),
        .raddr_b_i (ir_q[RS2_MSB:RS2_LSB]),
        .rdata_a_o (rd_a),
        .rdata_b_o (rd_b),
        .r8_o      (r8)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    // Next state and datapath next values; everything holds unless its phase updates it
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        pc_d    = pc_q;
        f1_d    = f1_q;
        f2_d    = f2_q;
        instr_d = instr_q;
        a_d     = a_q;
        b_d     = b_q;
        value_d = value_q;
        hl_d    = hl_q;
        c_d     = c_q;
        f3_d    = f3_q;
        ac_d    = ac_q;
        naddr_d = naddr_q;
        rf_we   = 1'b0;
        case (state_q)
            FETCH: begin
                if (bus.imem_valid) begin
                    ir_d    = bus.imem_data;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                instr_d = ir_op;
                a_d     = rd_a;
                b_d     = rd_b;
                value_d = ir_q[IMM_MSB:IMM_LSB];
                hl_d    = ir_q[HL_BIT];
                state_d = (ir_op == HALT_OP) ? HALT : EXEC;
            end
            EXEC: begin
                c_d     = bus.alu_c;
                f3_d    = bus.alu_f3;
                ac_d    = bus.alu_addrch;
                naddr_d = bus.alu_naddr[ADDR_W-1:0];
                state_d = WB;
            end
            WB: begin
                pc_d  = pc_q + ADDR_W'(1);
                rf_we = op_writes_reg(ir_op);
                if (op_writes_flags(ir_op)) begin
                    f1_d = f3_q;
                    f2_d = f1_q;
                end
                if (op_is_branch(ir_op) && ac_q) pc_d = naddr_q;
                state_d = FETCH;
            end
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            ir_q    <= '0;
            pc_q    <= RESET_PC;
            f1_q    <= 1'b0;
            f2_q    <= 1'b0;
            instr_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            value_q <= '0;
            hl_q    <= 1'b0;
            c_q     <= '0;
            f3_q    <= 1'b0;
            ac_q    <= 1'b0;
            naddr_q <= '0;
        end else begin
            ir_q    <= ir_d;
            pc_q    <= pc_d;
            f1_q    <= f1_d;
            f2_q    <= f2_d;
            instr_q <= instr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            value_q <= value_d;
            hl_q    <= hl_d;
            c_q     <= c_d;
            f3_q    <= f3_d;
            ac_q    <= ac_d;
            naddr_q <= naddr_d;
        end
    end

`ifdef ALU_SEQ_RETIRE_CNT_EN
    logic [31:0] retired_q;

    // One count per completed writeback; halting never reaches WB
    always_ff @(posedge clock) begin
        if (reset)              retired_q <= '0;
        else if (state_q == WB) retired_q <= retired_q + 32'd1;
    end

    assign retired = retired_q;
`endif

    // Strobes are forced low while reset is held so a mid-fetch reset drops the request at once
    assign bus.imem_req    = (state_q == FETCH) && !reset;
    assign bus.alu_en      = (state_q == EXEC) && !reset;
    assign bus.imem_addr   = pc_q;
    assign bus.alu_instr   = instr_q;
    assign bus.alu_a       = a_q;
    assign bus.alu_b       = b_q;
    assign bus.alu_reg8    = r8;
    assign bus.alu_value   = value_q;
    assign bus.alu_highlow = hl_q;
    assign bus.alu_f1      = f1_q;
    assign bus.alu_f2      = f2_q;
    assign pc              = pc_q;
    assign halted          = (state_q == HALT);

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed vector table plus hand sequences for reset, fetch stall and halt.
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] pc;
    logic        halted;
`ifdef ALU_SEQ_RETIRE_CNT_EN
    logic [31:0] retired;
`endif

    alu_seq_if #(.ADDR_W(16)) bus ();

    alu_sequencer #(.ADDR_W(16), .RESET_PC(16'h0000), .HALT_OP(7'd127)) dut (
        .clock  (clock),
        .reset  (reset),
        .bus    (bus),
        .pc     (pc),
        .halted (halted)
`ifdef ALU_SEQ_RETIRE_CNT_EN
        ,
        .retired(retired)
`endif
    );

    always #5 clock = ~clock;

    int ncmp = 0;
    int nerr = 0;

    typedef struct {
        logic [31:0] ins;
        int          dly;
        logic [31:0] c;
        logic        f3;
        logic        ac;
        logic [31:0] na;
        logic [15:0] addr;   // expected fetch address
        logic [31:0] ea;     // expected alu_a
        logic [31:0] eb;     // expected alu_b
        logic        ef1;    // flags after writeback
        logic        ef2;
        logic [31:0] er8;    // r8 after writeback
    } vec_t;

    vec_t v[16];

    localparam logic [31:0] JUNK = 32'hFE00_0000;  // a HALT word: latching it early would be visible

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] enc(input int op, input int rd, input int rs1, input int hl, input int imm);
        logic [31:0] w;
        w = '0;
        w[31:25] = 7'(op);
        w[24:21] = 4'(rd);
        w[20:17] = 4'(rs1);
        w[16]    = 1'(hl);
        w[15:0]  = 16'(imm);
        return w;
    endfunction

    task automatic run_vec(input int idx, input vec_t t);
        int          cyc;
        int          en;
        logic [31:0] cap_a, cap_b, cap_instr, cap_val, cap_hl;
        cyc = 0;
        while (!bus.imem_req && cyc < 10) begin step(); cyc++; end
        chk($sformatf("v%0d_req", idx), 32'(bus.imem_req), 32'd1);
        chk($sformatf("v%0d_addr", idx), 32'(bus.imem_addr), 32'(t.addr));
        chk($sformatf("v%0d_pc", idx), 32'(pc), 32'(t.addr));
        bus.alu_c = t.c; bus.alu_f3 = t.f3; bus.alu_addrch = t.ac; bus.alu_naddr = t.na;
        bus.imem_valid = 1'b0; bus.imem_data = JUNK;
        for (int k = 0; k < t.dly; k++) begin
            step();
            chk($sformatf("v%0d_req_hold", idx), 32'(bus.imem_req), 32'd1);
        end
        bus.imem_valid = 1'b1; bus.imem_data = t.ins;
        step();
        bus.imem_valid = 1'b0; bus.imem_data = JUNK;
        en = 0; cyc = 0;
        cap_a = 'x; cap_b = 'x; cap_instr = 'x; cap_val = 'x; cap_hl = 'x;
        while (!bus.imem_req && !halted && cyc < 8) begin
            if (bus.alu_en) begin
                en++;
                cap_a = bus.alu_a; cap_b = bus.alu_b; cap_instr = 32'(bus.alu_instr);
                cap_val = 32'(bus.alu_value); cap_hl = 32'(bus.alu_highlow);
            end
            step();
            cyc++;
        end
        chk($sformatf("v%0d_latency", idx), 32'(cyc), 32'd3);
        chk($sformatf("v%0d_en_cycles", idx), 32'(en), 32'd1);
        chk($sformatf("v%0d_instr", idx), cap_instr, 32'(t.ins[31:25]));
        chk($sformatf("v%0d_value", idx), cap_val, 32'(t.ins[15:0]));
        chk($sformatf("v%0d_highlow", idx), cap_hl, 32'(t.ins[16]));
        chk($sformatf("v%0d_a", idx), cap_a, t.ea);
        chk($sformatf("v%0d_b", idx), cap_b, t.eb);
        chk($sformatf("v%0d_f1", idx), 32'(bus.alu_f1), 32'(t.ef1));
        chk($sformatf("v%0d_f2", idx), 32'(bus.alu_f2), 32'(t.ef2));
        chk($sformatf("v%0d_reg8", idx), bus.alu_reg8, t.er8);
    endtask

    initial begin
        //          ins                  dly c          f3 ac na            addr      ea     eb     f1 f2 r8
        v[0]  = '{enc(5, 1, 0, 0, 5),    0, 32'd5,      0, 0, 32'h0,       16'h0000, 32'd0, 32'd0, 0, 0, 32'd0};
        v[1]  = '{enc(5, 2, 0, 0, 7),    0, 32'd7,      0, 0, 32'h0,       16'h0001, 32'd0, 32'd0, 0, 0, 32'd0};
        v[2]  = '{enc(0, 3, 1, 0, 2),    0, 32'd12,     0, 0, 32'h0,       16'h0002, 32'd5, 32'd7, 0, 0, 32'd0};
        v[3]  = '{enc(4, 8, 3, 0, 0),    0, 32'd12,     0, 0, 32'h0,       16'h0003, 32'd12, 32'd0, 0, 0, 32'd12};
        v[4]  = '{enc(5, 1, 0, 0, 9),    3, 32'd9,      0, 0, 32'h0,       16'h0004, 32'd0, 32'd0, 0, 0, 32'd12};
        v[5]  = '{enc(5, 2, 0, 1, 9),    0, 32'd9,      0, 0, 32'h0,       16'h0005, 32'd0, 32'd0, 0, 0, 32'd12};
        v[6]  = '{enc(8, 0, 1, 0, 2),    0, 32'd0,      1, 0, 32'h0,       16'h0006, 32'd9, 32'd9, 1, 0, 32'd12};
        v[7]  = '{enc(9, 0, 1, 0, 2),    0, 32'd0,      0, 0, 32'h0,       16'h0007, 32'd9, 32'd9, 0, 1, 32'd12};
        v[8]  = '{enc(16, 8, 3, 0, 0),   0, 32'hDEAD,   1, 0, 32'h0,       16'h0008, 32'd12, 32'd0, 0, 1, 32'd12};
        v[9]  = '{enc(15, 0, 0, 0, 0),   0, 32'd0,      0, 1, 32'h20,      16'h0009, 32'd0, 32'd0, 0, 1, 32'd12};
        v[10] = '{enc(15, 0, 0, 0, 0),   0, 32'd0,      0, 0, 32'h50,      16'h0020, 32'd0, 32'd0, 0, 1, 32'd12};
        v[11] = '{enc(14, 0, 0, 0, 0),   0, 32'd0,      0, 1, 32'h1FFFF,   16'h0021, 32'd0, 32'd0, 0, 1, 32'd12};
        v[12] = '{enc(20, 0, 0, 0, 0),   1, 32'd0,      1, 1, 32'h40,      16'hFFFF, 32'd0, 32'd0, 0, 1, 32'd12};
        v[13] = '{enc(13, 0, 1, 0, 2),   0, 32'd0,      1, 0, 32'h0,       16'h0000, 32'd9, 32'd9, 1, 0, 32'd12};
        v[14] = '{enc(7, 8, 2, 0, 1),    0, 32'h77,     0, 1, 32'h40,      16'h0001, 32'd9, 32'd9, 1, 0, 32'h77};
        v[15] = '{enc(8, 0, 3, 0, 8),    0, 32'd0,      0, 1, 32'h99,      16'h0002, 32'd12, 32'h77, 0, 1, 32'h77};

        bus.imem_valid = 1'b0; bus.imem_data = '0;
        bus.alu_c = '0; bus.alu_f3 = 1'b0; bus.alu_addrch = 1'b0; bus.alu_naddr = '0;

        // Power-on reset state
        step(); step();
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_en", 32'(bus.alu_en), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_instr", 32'(bus.alu_instr), 32'd0);
        chk("rst_ab", bus.alu_a | bus.alu_b, 32'd0);
        chk("rst_value", 32'({bus.alu_highlow, bus.alu_value}), 32'd0);
        chk("rst_flags", 32'({bus.alu_f1, bus.alu_f2}), 32'd0);
        chk("rst_reg8", bus.alu_reg8, 32'd0);
        reset = 1'b0;
        step();
        chk("fetch0_req", 32'(bus.imem_req), 32'd1);
        chk("fetch0_addr", 32'(bus.imem_addr), 32'd0);

        // Reset landing in the middle of a fetch
        reset = 1'b1;
        step();
        chk("midfetch_req", 32'(bus.imem_req), 32'd0);
        chk("midfetch_pc", 32'(pc), 32'd0);
        reset = 1'b0;
        step();
        chk("refetch_req", 32'(bus.imem_req), 32'd1);
        chk("refetch_addr", 32'(bus.imem_addr), 32'd0);

        for (int i = 0; i < 16; i++) begin
            run_vec(i, v[i]);
`ifdef ALU_SEQ_RETIRE_CNT_EN
            if (i == 2) chk("retired_3", retired, 32'd3);
`endif
        end

        // HALT: stops fetching, freezes pc, only reset leaves
        chk("halt_fetch_addr", 32'(bus.imem_addr), 32'd3);
        bus.imem_data = enc(127, 0, 0, 0, 0); bus.imem_valid = 1'b1;
        step();
        bus.imem_valid = 1'b0; bus.imem_data = '0;
        chk("halt_decode_en", 32'(bus.alu_en), 32'd0);
        step();
        for (int k = 0; k < 4; k++) begin
            chk("halt_halted", 32'(halted), 32'd1);
            chk("halt_req", 32'(bus.imem_req), 32'd0);
            chk("halt_en", 32'(bus.alu_en), 32'd0);
            chk("halt_pc", 32'(pc), 32'd3);
            bus.imem_valid = 1'b1;
            step();
        end
        bus.imem_valid = 1'b0;
`ifdef ALU_SEQ_RETIRE_CNT_EN
        chk("retired_16", retired, 32'd16);
`endif
        reset = 1'b1;
        step();
        chk("unhalt_halted", 32'(halted), 32'd0);
        chk("unhalt_pc", 32'(pc), 32'd0);
        chk("unhalt_req", 32'(bus.imem_req), 32'd0);
        chk("unhalt_reg8", bus.alu_reg8, 32'd0);
        chk("unhalt_flags", 32'({bus.alu_f1, bus.alu_f2}), 32'd0);
`ifdef ALU_SEQ_RETIRE_CNT_EN
        chk("retired_rst", retired, 32'd0);
`endif
        reset = 1'b0;
        step();
        chk("post_halt_req", 32'(bus.imem_req), 32'd1);
        chk("post_halt_addr", 32'(bus.imem_addr), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
